// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: pipeline latch enable/flush sequencing for the pipelined CPU.
// Handles load-use stalls, branch/jump flushes, data-memory wait, the halt
// drain sequence and the instruction-fetch request gate.
// Optional performance counters are compiled in when PIPE_PERF_EN is defined;
// otherwise stall_cnt and flush_cnt are tied to zero.
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             hazard,
    input  logic             branch,
    input  logic             jump,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             mem_halt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             imemREN,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_DWAIT  = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    // Counter is preloaded on halt entry so DRAIN lasts exactly DRAIN_CYCLES.
    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_drain_cnt;
    logic [3:0] w_drain_cnt_next;
    logic       r_halt;
    logic       w_halt_next;
    logic       w_mem_req;

    assign w_mem_req = mem_dREN | mem_dWEN;
    assign halt      = r_halt;

    // State, drain counter and halt flag registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state     <= S_RUN;
            r_drain_cnt <= 4'd0;
            r_halt      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_drain_cnt <= w_drain_cnt_next;
            r_halt      <= w_halt_next;
        end
    end

    // Next-state and latch-control decode from state and current inputs.
    always_comb begin
        w_state_next     = r_state;
        w_drain_cnt_next = r_drain_cnt;
        w_halt_next      = r_halt;
        pc_en            = 1'b0;
        ifid_en          = 1'b0;
        idex_en          = 1'b0;
        exmem_en         = 1'b0;
        memwb_en         = 1'b0;
        ifid_flush       = 1'b0;
        idex_flush       = 1'b0;
        exmem_flush      = 1'b0;
        imemREN          = 1'b0;
        case (r_state)
            S_RUN, S_DWAIT: begin
                // Fetch is suppressed while a data access is outstanding.
                imemREN = (r_state == S_RUN);
                if (w_mem_req && !dhit) begin
                    // Data miss: freeze everything until the cache answers.
                    w_state_next = S_DWAIT;
                end else if (dhit && !ihit) begin
                    // Data done but fetch missed: retire MEM, bubble into MEM.
                    memwb_en     = 1'b1;
                    exmem_en     = 1'b1;
                    exmem_flush  = 1'b1;
                    w_state_next = S_RUN;
                end else if (ihit) begin
                    pc_en        = 1'b1;
                    ifid_en      = 1'b1;
                    idex_en      = 1'b1;
                    exmem_en     = 1'b1;
                    memwb_en     = 1'b1;
                    w_state_next = S_RUN;
                    if (hazard) begin
                        // Load-use: hold PC and IF/ID, bubble into EX.
                        // A pending branch/jump is re-evaluated next cycle.
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end else if (branch || jump) begin
                        ifid_flush = 1'b1;
                    end
                end else begin
                    w_state_next = S_RUN;
                end
                // HALT reaching WB: squash everything younger and start draining.
                if (mem_halt && memwb_en) begin
                    pc_en            = 1'b0;
                    ifid_en          = 1'b1;
                    idex_en          = 1'b1;
                    exmem_en         = 1'b1;
                    ifid_flush       = 1'b1;
                    idex_flush       = 1'b1;
                    exmem_flush      = 1'b1;
                    w_drain_cnt_next = DRAIN_LOAD;
                    w_state_next     = S_DRAIN;
                end
            end
            S_DRAIN: begin
                memwb_en = 1'b1;
                if (r_drain_cnt == 4'd0) begin
                    w_state_next = S_HALTED;
                    w_halt_next  = 1'b1;
                end else begin
                    w_drain_cnt_next = r_drain_cnt - 4'd1;
                end
            end
            S_HALTED: begin
                w_state_next = S_HALTED;
            end
            default: begin
                w_state_next = S_RUN;
            end
        endcase
    end

`ifdef PIPE_PERF_EN
    logic             w_active;
    logic             w_bj_flush;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    // In RUN/DWAIT an IF/ID flush comes from branch/jump unless halt is entering.
    assign w_active   = (r_state == S_RUN) || (r_state == S_DWAIT);
    assign w_bj_flush = w_active && ifid_flush && (w_state_next != S_DRAIN);

    // Stall and control-flush counters; wrap naturally, frozen in DRAIN/HALTED.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_active && !pc_en) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_bj_flush) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
